// File: rtl/apb_gpio_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_gpio_ext                                                  |
// | Brief    : APB GPIO with set/clear/toggle aliases, synchronised and      |
// |            debounced inputs, and edge/level interrupt flags.             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module apb_gpio_ext #(
  parameter int NBITS       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DBW         = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [7:0]        paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [NBITS-1:0]  gpio_in,
  output logic [NBITS-1:0]  gpio_out,
  output logic [NBITS-1:0]  gpio_oe,
  output logic              irq
);

  localparam logic [1:0] c_op_set = 2'd0;
  localparam logic [1:0] c_op_or  = 2'd1;
  localparam logic [1:0] c_op_and = 2'd2;
  localparam logic [1:0] c_op_xor = 2'd3;

  localparam logic [2:0] c_idx_data  = 3'd0;
  localparam logic [2:0] c_idx_out   = 3'd1;
  localparam logic [2:0] c_idx_dir   = 3'd2;
  localparam logic [2:0] c_idx_imask = 3'd3;
  localparam logic [2:0] c_idx_ipol  = 3'd4;
  localparam logic [2:0] c_idx_iedge = 3'd5;
  localparam logic [2:0] c_idx_iflag = 3'd6;
  localparam logic [2:0] c_idx_dbper = 3'd7;

  logic [NBITS-1:0]                  r_out, r_dir, r_imask, r_ipol, r_iedge, r_iflag;
  logic [DBW-1:0]                    r_dbper, r_pcnt;
  logic [SYNC_STAGES-1:0][NBITS-1:0] r_sync;
  logic [NBITS-1:0]                  r_stable, r_stable_d;
  logic [NBITS-1:0][1:0]             r_dbcnt;
  logic                              r_irq;

  logic             w_access, w_valid, w_wr, w_tick;
  logic [2:0]       w_idx;
  logic [1:0]       w_op;
  logic [31:0]      w_rdata;
  logic [NBITS-1:0] w_wdata, w_sync, w_edge, w_level, w_event, w_clr;
  logic             w_unused;

  assign w_access = psel & penable;
  assign w_wr     = w_access & pwrite & w_valid;
  assign w_wdata  = pwdata[NBITS-1:0];
  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_unused = &{1'b0, pwdata};

  // Aliases map onto the base register index with a read-modify-write op.
  always_comb begin
    w_valid = 1'b1;
    w_idx   = paddr[4:2];
    w_op    = c_op_set;
    case (paddr)
      8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C: ;
      8'h54, 8'h58, 8'h5C: begin w_idx = {1'b0, paddr[3:2]}; w_op = c_op_or;  end
      8'h64, 8'h68, 8'h6C: begin w_idx = {1'b0, paddr[3:2]}; w_op = c_op_and; end
      8'h74, 8'h78, 8'h7C: begin w_idx = {1'b0, paddr[3:2]}; w_op = c_op_xor; end
      default:             begin w_valid = 1'b0; w_idx = c_idx_data; end
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      c_idx_data:  w_rdata[NBITS-1:0] = r_stable;
      c_idx_out:   w_rdata[NBITS-1:0] = r_out;
      c_idx_dir:   w_rdata[NBITS-1:0] = r_dir;
      c_idx_imask: w_rdata[NBITS-1:0] = r_imask;
      c_idx_ipol:  w_rdata[NBITS-1:0] = r_ipol;
      c_idx_iedge: w_rdata[NBITS-1:0] = r_iedge;
      c_idx_iflag: w_rdata[NBITS-1:0] = r_iflag;
      default:     w_rdata[DBW-1:0]   = r_dbper;
    endcase
  end

  assign prdata   = (rstn && w_access && w_valid) ? w_rdata : 32'd0;
  assign pslverr  = rstn & w_access & ~w_valid;
  assign pready   = 1'b1;
  assign gpio_out = r_out;
  assign gpio_oe  = r_dir;
  assign irq      = r_irq;

  function automatic logic [NBITS-1:0] f_apply(input logic [1:0] op,
                                               input logic [NBITS-1:0] cur,
                                               input logic [NBITS-1:0] wd);
    case (op)
      c_op_or:  return cur | wd;
      c_op_and: return cur & wd;
      c_op_xor: return cur ^ wd;
      default:  return wd;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_imask <= '0;
      r_ipol  <= '0;
      r_iedge <= '0;
      r_dbper <= '0;
    end else if (w_wr) begin
      case (w_idx)
        c_idx_out:   r_out   <= f_apply(w_op, r_out, w_wdata);
        c_idx_dir:   r_dir   <= f_apply(w_op, r_dir, w_wdata);
        c_idx_imask: r_imask <= f_apply(w_op, r_imask, w_wdata);
        c_idx_ipol:  r_ipol  <= w_wdata;
        c_idx_iedge: r_iedge <= w_wdata;
        c_idx_dbper: r_dbper <= pwdata[DBW-1:0];
        default: ;
      endcase
    end
  end

  assign w_tick = (r_pcnt == r_dbper);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pcnt <= '0;
    end else if ((w_wr && w_idx == c_idx_dbper) || w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + DBW'(1);
    end
  end

  // A pin's counter only advances while it disagrees with the debounced value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync     <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_dbcnt    <= '0;
    end else begin
      r_sync[0]  <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_stable_d <= r_stable;
      for (int i = 0; i < NBITS; i++) begin
        if (r_dbper == '0) begin
          r_stable[i] <= w_sync[i];
          r_dbcnt[i]  <= 2'd0;
        end else if (w_sync[i] == r_stable[i]) begin
          r_dbcnt[i]  <= 2'd0;
        end else if (w_tick) begin
          if (r_dbcnt[i] == 2'd2) begin
            r_stable[i] <= w_sync[i];
            r_dbcnt[i]  <= 2'd0;
          end else begin
            r_dbcnt[i]  <= r_dbcnt[i] + 2'd1;
          end
        end
      end
    end
  end

  assign w_edge  = (r_ipol & r_stable & ~r_stable_d) | (~r_ipol & ~r_stable & r_stable_d);
  assign w_level = ~(r_stable ^ r_ipol);
  assign w_event = (r_iedge & w_edge) | (~r_iedge & w_level);
  assign w_clr   = (w_wr && w_idx == c_idx_iflag) ? w_wdata : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_iflag <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_iflag <= (r_iflag & ~w_clr) | (w_event & r_imask);
      r_irq   <= |(r_iflag & r_imask);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_apb_gpio_ext                                               |
// | Brief    : Directed self-checking bench for apb_gpio_ext.                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_apb_gpio_ext;

  logic        clk = 1'b0;
  logic        rstn;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  gpio_in, gpio_out, gpio_oe;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  apb_gpio_ext #(.NBITS(8), .SYNC_STAGES(2), .DBW(16)) u_dut (
    .clk(clk), .rstn(rstn),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1'b1; #1; err = pslverr;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1; #1; d = prdata; err = pslverr;
    @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
  endtask

  // Hold a continuous read of DATA so prdata tracks the debounced inputs.
  task automatic watch_data();
    @(negedge clk); psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h00;
  endtask

  task automatic idle_bus();
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  logic [7:0]  regs [8];

  initial begin
    regs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    rstn = 1'b0; gpio_in = 8'h00;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h40; pwdata = 32'hFF;
    repeat (2) @(negedge clk);
    check("rst_gpio_out", {24'd0, gpio_out}, 32'h0);
    check("rst_gpio_oe",  {24'd0, gpio_oe},  32'h0);
    check("rst_irq",      {31'd0, irq},      32'h0);
    check("rst_pready",   {31'd0, pready},   32'h1);
    check("rst_pslverr",  {31'd0, pslverr},  32'h0);
    check("rst_prdata",   prdata,            32'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk); rstn = 1'b1;

    // Alias read-modify-write on OUT
    apb_write(8'h04, 32'h00, er);
    apb_write(8'h54, 32'h5A, er); check("or_out",  {24'd0, gpio_out}, 32'h5A);
    apb_write(8'h64, 32'h0F, er); check("and_out", {24'd0, gpio_out}, 32'h0A);
    apb_write(8'h74, 32'hFF, er); check("xor_out", {24'd0, gpio_out}, 32'hF5);
    check("xor_pslverr", {31'd0, er}, 32'h0);
    apb_read(8'h54, rd, er);      check("alias_rd", rd, 32'hF5);
    apb_write(8'h08, 32'hFFFF_FF3C, er); check("dir_oe", {24'd0, gpio_oe}, 32'h3C);
    apb_read(8'h08, rd, er);      check("dir_rd", rd, 32'h3C);

    // Bypass latency: SYNC_STAGES+1 edges from gpio_in to DATA
    watch_data();
    gpio_in = 8'h81;
    repeat (2) @(negedge clk); check("lat_early", prdata, 32'h00);
    @(negedge clk);            check("lat_exact", prdata, 32'h81);
    gpio_in = 8'h00;
    repeat (5) @(negedge clk); check("lat_back", prdata, 32'h00);
    idle_bus();

    // Debounce with DBPER=3: tick every 4 cycles, 3 ticks to accept
    apb_write(8'h1C, 32'h0003_0003, er);
    apb_read(8'h1C, rd, er);   check("dbper_rd", rd, 32'h0003);
    watch_data();
    gpio_in = 8'h01;
    repeat (6) @(negedge clk); gpio_in = 8'h00;
    repeat (6) @(negedge clk); check("db_glitch", prdata, 32'h00);
    gpio_in = 8'h01;
    repeat (8) @(negedge clk); check("db_early", prdata, 32'h00);
    repeat (12) @(negedge clk); check("db_accept", prdata, 32'h01);
    idle_bus();

    // Interrupts in bypass mode
    gpio_in = 8'h00;
    apb_write(8'h1C, 32'h0, er);
    repeat (4) @(negedge clk);
    apb_write(8'h14, 32'h01, er);
    apb_write(8'h10, 32'h01, er);
    apb_write(8'h0C, 32'h01, er);
    apb_read(8'h18, rd, er);   check("iflag_idle", rd, 32'h00);
    @(negedge clk); gpio_in = 8'h01;
    repeat (6) @(negedge clk);
    check("irq_rise", {31'd0, irq}, 32'h1);
    apb_read(8'h18, rd, er);   check("iflag_rise", rd, 32'h01);
    apb_write(8'h18, 32'h01, er);
    repeat (2) @(negedge clk); check("irq_w1c", {31'd0, irq}, 32'h0);
    apb_read(8'h18, rd, er);   check("iflag_w1c", rd, 32'h00);
    apb_write(8'h14, 32'h00, er);
    repeat (3) @(negedge clk);
    apb_read(8'h18, rd, er);   check("iflag_level", rd, 32'h01);
    check("irq_level", {31'd0, irq}, 32'h1);
    apb_write(8'h18, 32'h01, er);
    repeat (2) @(negedge clk); check("irq_set_wins", {31'd0, irq}, 32'h1);
    apb_write(8'h6C, 32'h00, er);
    repeat (2) @(negedge clk); check("irq_masked", {31'd0, irq}, 32'h0);
    apb_read(8'h18, rd, er);   check("iflag_kept", rd, 32'h01);
    apb_read(8'h0C, rd, er);   check("imask_and", rd, 32'h00);

    // Unmapped address
    apb_read(8'h40, rd, er);
    check("err_rd_slv", {31'd0, er}, 32'h1);
    check("err_rd_data", rd, 32'h0);
    apb_write(8'h40, 32'hFF, er);
    check("err_wr_slv", {31'd0, er}, 32'h1);
    apb_read(8'h04, rd, er);   check("err_no_change", rd, 32'hF5);

    // Reset during a write's access phase
    gpio_in = 8'h00;
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hAA;
    @(negedge clk); penable = 1'b1; #2; rstn = 1'b0;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("mid_rst_out", {24'd0, gpio_out}, 32'h0);
    @(negedge clk); rstn = 1'b1;
    foreach (regs[k]) begin
      apb_read(regs[k], rd, er);
      check($sformatf("post_rst_%0h", regs[k]), rd, 32'h0);
    end
    check("post_rst_irq", {31'd0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
